spi_frame_master: RTL and testbench

SPI_FRAME_MASTER -- requirements
Module: spi_frame_master

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_sclk_gen.sv | 42 ++++
 rtl/spi_frame_master.sv | 136 +++++++++++++
 tb/tb_spi_frame_master.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared widths, FSM state encoding and counter sizing for the SPI frame master.
package spi_pkg;

  localparam int SPI_FRAME_W = 16;
  localparam int SPI_ADDR_W  = 7;
  localparam int SPI_DATA_W  = 8;
  localparam int SPI_BIT_W   = $clog2(SPI_FRAME_W);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_state_e;

  // Width that holds the largest of the chip-select timing loads without wrapping.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Mode-0 SCLK generator: HALF_PERIOD cycles low then high while enabled, forced low otherwise.
// rise_o/fall_o flag the clk edge at which sclk_o will toggle.
module spi_sclk_gen #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int               HP_W    = $clog2(HALF_PERIOD);
  localparam logic [HP_W-1:0]  HP_LAST = HP_W'(HALF_PERIOD - 1);
  localparam logic [HP_W-1:0]  HP_ONE  = HP_W'(1);

  logic [HP_W-1:0] hp_cnt_q;
  logic            sclk_q;
  logic            toggle_w;

  assign toggle_w = en_i && (hp_cnt_q == HP_LAST);
  assign rise_o   = toggle_w && !sclk_q;
  assign fall_o   = toggle_w && sclk_q;
  assign sclk_o   = sclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp_cnt_q <= '0;
      sclk_q   <= 1'b0;
    end else if (!en_i) begin
      hp_cnt_q <= '0;
      sclk_q   <= 1'b0;
    end else if (toggle_w) begin
      hp_cnt_q <= '0;
      sclk_q   <= ~sclk_q;
    end else begin
      hp_cnt_q <= hp_cnt_q + HP_ONE;
    end
  end

endmodule

// File: rtl/spi_frame_master.sv
// SPI mode-0 master shifting one 16-bit {rw, addr, data} frame MSB-first per accepted request.
// Single-entry: in_ready only in IDLE, so requests stall while a frame and its CS gap are in flight.
module spi_frame_master
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int CS_SETUP    = 4,
  parameter int CS_HOLD     = 4,
  parameter int CS_GAP      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_rw,
  input  logic [SPI_ADDR_W-1:0] in_addr,
  input  logic [SPI_DATA_W-1:0] in_data,
  output logic                  sclk,
  output logic                  copi,
  output logic                  n_cs,
  output logic                  busy,
  output logic                  done
);

  localparam int                   CNT_W   = cnt_width(CS_SETUP, CS_HOLD, CS_GAP);
  localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);
  localparam logic [SPI_BIT_W-1:0] BIT_ONE = SPI_BIT_W'(1);

  spi_state_e             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [SPI_BIT_W-1:0]   bit_q;
  logic                   last_q;
  logic [SPI_FRAME_W-1:0] frame_q;
  logic                   n_cs_q;
  logic                   copi_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   in_ready_q;

  logic sclk_w;
  logic rise_w;
  logic fall_w;
  logic accept_w;

  assign accept_w = in_valid && in_ready_q;

  spi_sclk_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_sclk_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (state_q == SHIFT),
    .sclk_o(sclk_w),
    .rise_o(rise_w),
    .fall_o(fall_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      last_q     <= 1'b0;
      frame_q    <= '0;
      n_cs_q     <= 1'b1;
      copi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (accept_w) begin
            frame_q    <= {in_rw, in_addr, in_data};
            copi_q     <= in_rw;
            n_cs_q     <= 1'b0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
            cnt_q      <= CNT_W'(CS_SETUP - 1);
            bit_q      <= SPI_BIT_W'(SPI_FRAME_W - 1);
            last_q     <= 1'b0;
            state_q    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == '0) state_q <= SHIFT;
          else             cnt_q   <= cnt_q - CNT_ONE;
        end
        SHIFT: begin
          // Bit 0 has been presented on a rise; the following fall closes the frame.
          if (rise_w && (bit_q == '0)) last_q <= 1'b1;
          if (fall_w) begin
            if (last_q) begin
              state_q <= HOLD;
              cnt_q   <= CNT_W'(CS_HOLD - 1);
            end else begin
              bit_q  <= bit_q - BIT_ONE;
              copi_q <= frame_q[bit_q - BIT_ONE];
            end
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_q <= GAP;
            n_cs_q  <= 1'b1;
            copi_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= CNT_W'(CS_GAP - 1);
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign sclk     = sclk_w;
  assign copi     = copi_q;
  assign n_cs     = n_cs_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: default-timing instance (0) and HALF_PERIOD=2 instance (1),
// each watched by a mode-0 sampler that records every completed chip-select window.
module tb_spi_frame_master;

  localparam int HP0 = 4;
  localparam int HP1 = 2;
  localparam int CSS = 4;
  localparam int CSH = 4;
  localparam int CSG = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst_n, in_valid, in_ready, in_rw, sclk, copi, n_cs, busy, done;
  logic [1:0][6:0] in_addr;
  logic [1:0][7:0] in_data;

  spi_frame_master u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_rw(in_rw[0]), .in_addr(in_addr[0]), .in_data(in_data[0]),
    .sclk(sclk[0]), .copi(copi[0]), .n_cs(n_cs[0]), .busy(busy[0]), .done(done[0])
  );

  spi_frame_master #(.HALF_PERIOD(HP1)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_rw(in_rw[1]), .in_addr(in_addr[1]), .in_data(in_data[1]),
    .sclk(sclk[1]), .copi(copi[1]), .n_cs(n_cs[1]), .busy(busy[1]), .done(done[1])
  );

  typedef struct {
    int dut;
    int cap;
    int rises;
    int low_len;
    int gap;
    int done_end;
  } rec_t;

  typedef struct {
    int       dut;
    bit       rw;
    bit [6:0] addr;
    bit [7:0] data;
    int       exp_frame;
    int       exp_low;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  rec_t        mon_q[$];
  int          done_cnt[2], bad_phase[2], copi_hi_chg[2];
  int          m_low[2], m_rises[2], m_phase[2], m_gap[2], m_gap_start[2];
  bit          m_have_rise[2], m_after_fall[2], m_psclk[2], m_pcopi[2], m_pncs[2];
  logic [15:0] m_cap[2];

  function automatic int hp_of(input int i);
    return (i == 0) ? HP0 : HP1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Sampler runs on the falling clk edge, half a cycle clear of DUT updates.
  always @(negedge clk) begin
    rec_t r;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) begin
        m_cap[i] = '0; m_rises[i] = 0; m_low[i] = 0; m_phase[i] = 0; m_gap[i] = 0;
        m_have_rise[i] = 1'b0; m_after_fall[i] = 1'b0;
        m_psclk[i] = 1'b0; m_pcopi[i] = 1'b0; m_pncs[i] = 1'b1;
      end else begin
        if (done[i]) done_cnt[i]++;
        if (!n_cs[i]) begin
          if (m_pncs[i]) begin
            m_cap[i] = '0; m_rises[i] = 0; m_low[i] = 0; m_phase[i] = 0;
            m_after_fall[i] = 1'b0;
            m_gap_start[i] = m_have_rise[i] ? m_gap[i] : -1;
          end
          m_low[i]++;
          if (sclk[i] && !m_psclk[i]) begin
            m_cap[i] = {m_cap[i][14:0], copi[i]};
            m_rises[i]++;
            if (m_after_fall[i] && m_phase[i] != hp_of(i)) bad_phase[i]++;
            m_phase[i] = 0;
          end else if (!sclk[i] && m_psclk[i]) begin
            if (m_phase[i] != hp_of(i)) bad_phase[i]++;
            m_phase[i] = 0;
            m_after_fall[i] = 1'b1;
          end
          m_phase[i]++;
          if (sclk[i] && m_psclk[i] && copi[i] != m_pcopi[i]) copi_hi_chg[i]++;
        end else begin
          if (sclk[i]) bad_phase[i]++;
          if (!m_pncs[i]) begin
            r.dut = i; r.cap = int'(m_cap[i]); r.rises = m_rises[i]; r.low_len = m_low[i];
            r.gap = m_gap_start[i]; r.done_end = int'(done[i]);
            mon_q.push_back(r);
            m_have_rise[i] = 1'b1;
            m_gap[i] = 0;
          end
          m_gap[i]++;
        end
        m_psclk[i] = sclk[i]; m_pcopi[i] = copi[i]; m_pncs[i] = n_cs[i];
      end
    end
  end

  function automatic int count_rec(input int i);
    int n = 0;
    foreach (mon_q[k]) if (mon_q[k].dut == i) n++;
    return n;
  endfunction

  task automatic pop_rec(input int i, output rec_t r, output bit ok);
    ok = 1'b0;
    r = '{default: 0};
    for (int k = 0; k < mon_q.size(); k++) begin
      if (mon_q[k].dut == i) begin
        r = mon_q[k];
        mon_q.delete(k);
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send(input int i, input bit rw, input bit [6:0] a, input bit [7:0] d);
    int t = 0;
    @(negedge clk);
    while (!in_ready[i] && t < 2000) begin @(negedge clk); t++; end
    if (!in_ready[i]) check("send_ready_timeout", 0, 1);
    in_valid[i] = 1'b1; in_rw[i] = rw; in_addr[i] = a; in_data[i] = d;
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
    check("accept_state", int'({n_cs[i], copi[i], busy[i], in_ready[i]}), int'({1'b0, rw, 1'b1, 1'b0}));
  endtask

  task automatic wait_idle(input int i);
    int t = 0;
    @(negedge clk);
    while (!(in_ready[i] && !busy[i]) && t < 3000) begin @(negedge clk); t++; end
    check("idle_timeout", int'(in_ready[i] && !busy[i]), 1);
  endtask

  task automatic check_frame(input int i, input int exp_frame, input int exp_low,
                             input string tag, output int gap);
    rec_t r;
    bit   ok;
    pop_rec(i, r, ok);
    gap = r.gap;
    check({tag, "_present"}, int'(ok), 1);
    if (ok) begin
      check({tag, "_frame"}, r.cap, exp_frame);
      check({tag, "_rises"}, r.rises, 16);
      check({tag, "_ncs_low"}, r.low_len, exp_low);
      check({tag, "_done"}, r.done_end, 1);
    end
  endtask

  vec_t vecs[4];

  initial begin
    int       t, g, rises, d0, n0, stray, di, exp;
    bit       prev, rw;
    bit [6:0] a;
    bit [7:0] d;

    rst_n = 2'b00; in_valid = '0; in_rw = '0; in_addr = '0; in_data = '0;
    vecs[0] = '{0, 1'b1, 7'h00, 8'hA5, 'h80A5, 136};
    vecs[1] = '{1, 1'b0, 7'h7F, 8'h3C, 'h7F3C, 72};
    vecs[2] = '{0, 1'b0, 7'h55, 8'h0F, 'h550F, 136};
    vecs[3] = '{1, 1'b1, 7'h2A, 8'hF0, 'hAAF0, 72};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++)
      check($sformatf("reset_outputs%0d", i),
            int'({sclk[i], n_cs[i], copi[i], busy[i], in_ready[i], done[i]}), 'b010000);
    rst_n = 2'b11;
    @(posedge clk); #1;
    check("release_ready0", int'(in_ready[0]), 1);
    check("release_ready1", int'(in_ready[1]), 1);

    for (int v = 0; v < 4; v++) begin
      send(vecs[v].dut, vecs[v].rw, vecs[v].addr, vecs[v].data);
      wait_idle(vecs[v].dut);
      check_frame(vecs[v].dut, vecs[v].exp_frame, vecs[v].exp_low, $sformatf("vec%0d", v), g);
    end

    // Back-to-back with in_valid held high across both accepts.
    @(negedge clk);
    in_rw[0] = 1'b1; in_addr[0] = 7'h01; in_data[0] = 8'h12; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_addr[0] = 7'h02; in_data[0] = 8'h34;
    t = 0;
    @(negedge clk);
    while (!in_ready[0] && t < 2000) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    wait_idle(0);
    check_frame(0, 'h8112, 136, "b2b_first", g);
    check_frame(0, 'h8234, 136, "b2b_second", g);
    check("b2b_ncs_high", g, CSG + 1);

    // Request pulsed while busy must be dropped.
    d0 = done_cnt[0]; n0 = count_rec(0);
    send(0, 1'b0, 7'h12, 8'h34);
    repeat (30) @(negedge clk);
    in_valid[0] = 1'b1; in_rw[0] = 1'b1; in_addr[0] = 7'h7F; in_data[0] = 8'hFF;
    @(negedge clk);
    in_valid[0] = 1'b0;
    wait_idle(0);
    repeat (CSG + 10) @(negedge clk);
    check("ignore_one_frame", count_rec(0) - n0, 1);
    check("ignore_one_done", done_cnt[0] - d0, 1);
    check("ignore_still_idle", int'(busy[0]), 0);
    check_frame(0, 'h1234, 136, "ignore", g);

    // Reset after the fifth sclk rise, then a clean frame.
    d0 = done_cnt[0]; n0 = count_rec(0);
    send(0, 1'b1, 7'h33, 8'hCC);
    rises = 0; prev = sclk[0]; t = 0;
    while (rises < 5 && t < 2000) begin
      @(posedge clk); #1;
      if (sclk[0] && !prev) rises++;
      prev = sclk[0];
      t++;
    end
    check("rst_mid_fifth_rise", rises, 5);
    #1 rst_n[0] = 1'b0;
    #1;
    check("rst_mid_ncs_sclk", int'({n_cs[0], sclk[0]}), 'b10);
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (sclk[0] || !n_cs[0] || done[0]) stray++;
    end
    check("rst_mid_quiet", stray, 0);
    check("rst_mid_no_done", done_cnt[0] - d0, 0);
    check("rst_mid_no_record", count_rec(0) - n0, 0);
    rst_n[0] = 1'b1;
    send(0, 1'b1, 7'h01, 8'h55);
    wait_idle(0);
    check_frame(0, 'h8155, 136, "post_rst", g);

    // Random frames on both instances against the arithmetic frame/length model.
    for (int k = 0; k < 20; k++) begin
      di = int'($urandom_range(1, 0));
      rw = 1'($urandom_range(1, 0));
      a  = 7'($urandom);
      d  = 8'($urandom);
      exp = int'(rw) * 32768 + int'(a) * 256 + int'(d);
      send(di, rw, a, d);
      wait_idle(di);
      check_frame(di, exp, CSS + 2 * 16 * hp_of(di) + CSH, $sformatf("rnd%0d", k), g);
    end

    check("phase_len0", bad_phase[0], 0);
    check("phase_len1", bad_phase[1], 0);
    check("copi_stable_high0", copi_hi_chg[0], 0);
    check("copi_stable_high1", copi_hi_chg[1], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
